// File: rtl/seg_reader.sv
// Recovers the character word shown on a multiplexed, active-low 4-digit 7-segment display.
// Each digit is accepted after a stable dwell, and a full word is committed once all four digits are captured.
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an_n,
  input  logic [6:0] seg_n,
  output logic [3:0] char0,
  output logic [3:0] char1,
  output logic [3:0] char2,
  output logic [3:0] char3,
  output logic       word_valid,
  output logic       char_err,
  output logic       scan_err,
  output logic [7:0] word_cnt
);

  typedef enum logic {COLLECT, COMMIT} state_t;

  // The dwell is counted from 0 on the second identical sample, so acceptance is
  // due once the counter shows STABLE_CYCLES-2.
  localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 2);

  state_t      state_reg, state_next;
  logic [3:0]  an_reg, an_prev_reg;
  logic [6:0]  seg_reg, seg_prev_reg;
  logic [7:0]  cnt_reg, cnt_next;
  logic        accepted_reg, accepted_next;
  logic [3:0]  mask_reg, mask_next;
  logic [3:0]  shadow_reg [4];
  logic [3:0]  char_reg [4];
  logic        word_valid_reg, word_valid_next;
  logic        char_err_reg, char_err_next;
  logic        scan_err_reg, scan_err_next;
  logic [7:0]  word_cnt_reg;
  logic        first_reg;
  logic        commit_go;

  logic        same, idle, single, multi, accept;
  logic [3:0]  sel;
  logic [3:0]  code;
  logic [15:0] shadow_word, char_word;
  logic [3:0]  bad_digit;

  function automatic logic [3:0] decode(input logic [6:0] m);
    logic [3:0] c;
    case (m)
      7'h00:   c = 4'd0;
      7'h77:   c = 4'd1;
      7'h7C:   c = 4'd2;
      7'h39:   c = 4'd3;
      7'h5E:   c = 4'd4;
      7'h76:   c = 4'd5;
      7'h54:   c = 4'd6;
      7'h3F:   c = 4'd7;
      7'h73:   c = 4'd8;
      7'h6D:   c = 4'd9;
      7'h78:   c = 4'd10;
      7'h6E:   c = 4'd11;
      default: c = 4'd15;
    endcase
    return c;
  endfunction

  // Sample classification and dwell tracking.
  always_comb begin
    sel    = ~an_reg;
    same   = ({an_reg, seg_reg} == {an_prev_reg, seg_prev_reg});
    idle   = (an_reg == 4'hF);
    single = !idle && ((sel & (sel - 4'd1)) == 4'd0);
    multi  = !idle && !single;
    code   = decode(~seg_reg);
    accept = single && same && !accepted_reg && (cnt_reg >= ACCEPT_AT);

    cnt_next = cnt_reg;
    if (!single || !same)
      cnt_next = 8'd0;
    else if (cnt_reg != 8'hFF)
      cnt_next = cnt_reg + 8'd1;

    accepted_next = single && same && (accepted_reg || accept);
    scan_err_next = multi && !same;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign shadow_word[gi*4 +: 4] = shadow_reg[gi];
      assign char_word[gi*4 +: 4]   = char_reg[gi];
      assign bad_digit[gi]          = (shadow_reg[gi] == 4'd15);

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= 4'd0;
          char_reg[gi]   <= 4'd0;
        end else begin
          if (accept && sel[gi])
            shadow_reg[gi] <= code;
          if (commit_go)
            char_reg[gi] <= shadow_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= COLLECT;
    else
      state_reg <= state_next;
  end

  // The word is latched on the edge entering COMMIT, so word_valid and the new
  // characters are visible together throughout the COMMIT cycle.
  always_comb begin
    state_next      = state_reg;
    commit_go       = 1'b0;
    mask_next       = mask_reg;
    word_valid_next = 1'b0;
    char_err_next   = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (mask_reg == 4'hF) begin
          state_next = COMMIT;
          commit_go  = 1'b1;
        end
      end
      COMMIT: begin
        state_next = COLLECT;
        mask_next  = 4'h0;
      end
      default: state_next = COLLECT;
    endcase
    if (accept)
      mask_next = mask_next | sel;
    if (commit_go && (first_reg || (shadow_word != char_word))) begin
      word_valid_next = 1'b1;
      char_err_next   = |bad_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg         <= 4'hF;
      seg_reg        <= 7'h7F;
      an_prev_reg    <= 4'hF;
      seg_prev_reg   <= 7'h7F;
      cnt_reg        <= 8'd0;
      accepted_reg   <= 1'b0;
      mask_reg       <= 4'h0;
      word_valid_reg <= 1'b0;
      char_err_reg   <= 1'b0;
      scan_err_reg   <= 1'b0;
      word_cnt_reg   <= 8'd0;
      first_reg      <= 1'b1;
    end else begin
      an_reg         <= an_n;
      seg_reg        <= seg_n;
      an_prev_reg    <= an_reg;
      seg_prev_reg   <= seg_reg;
      cnt_reg        <= cnt_next;
      accepted_reg   <= accepted_next;
      mask_reg       <= mask_next;
      word_valid_reg <= word_valid_next;
      char_err_reg   <= char_err_next;
      scan_err_reg   <= scan_err_next;
      if (word_valid_next)
        word_cnt_reg <= word_cnt_reg + 8'd1;
      if (commit_go)
        first_reg <= 1'b0;
    end
  end

  assign char0      = char_reg[0];
  assign char1      = char_reg[1];
  assign char2      = char_reg[2];
  assign char3      = char_reg[3];
  assign word_valid = word_valid_reg;
  assign char_err   = char_err_reg;
  assign scan_err   = scan_err_reg;
  assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: stimulus pushes expected words, a monitor pops them on word_valid.
// Directed frames cover duplicate suppression, short dwells, multi-enable scans, bad glyphs and reset.
module tb_seg_reader;
  localparam int SC = 4;

  localparam logic [6:0] M_H = 7'h76, M_A = 7'h77, M_P = 7'h73, M_Y = 7'h6E;
  localparam logic [6:0] M_S = 7'h6D, M_T = 7'h78, M_O = 7'h3F, M_B = 7'h7C;
  localparam logic [6:0] M_N = 7'h54, M_D = 7'h5E, M_X = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an_n = 4'hF;
  logic [6:0] seg_n = 7'h7F;
  logic [3:0] char0, char1, char2, char3;
  logic       word_valid, char_err, scan_err;
  logic [7:0] word_cnt;

  typedef struct {
    logic [15:0] chars;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wv_seen = 0;
  int scan_seen = 0;
  int t_d3 = 0;
  bit lat_arm = 1'b0;

  seg_reader #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3),
    .word_valid(word_valid), .char_err(char_err), .scan_err(scan_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                      input logic [3:0] c3, input logic err, input logic [7:0] cnt);
    exp_t e;
    e.chars = {c3, c2, c1, c0};
    e.err   = err;
    e.cnt   = cnt;
    sb.push_back(e);
  endtask

  // Monitor: every word_valid pulse must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (scan_err) scan_seen = scan_seen + 1;
      if (char_err && !word_valid) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL char_err_alone: char_err=1 while word_valid=0 at cycle %0d", cyc);
      end
      if (word_valid) begin
        wv_seen = wv_seen + 1;
        if (sb.size() == 0) begin
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL unexpected_word: chars=%h,%h,%h,%h cnt=%0d with nothing expected",
                   char0, char1, char2, char3, word_cnt);
        end else begin
          e = sb.pop_front();
          $display("word %0d: chars=%0d,%0d,%0d,%0d err=%0d cnt=%0d", wv_seen,
                   char0, char1, char2, char3, char_err, word_cnt);
          chk("word_chars", int'({char3, char2, char1, char0}), int'(e.chars));
          chk("word_err", int'(char_err), int'(e.err));
          chk("word_cnt", int'(word_cnt), int'(e.cnt));
          if (lat_arm) begin
            chk("latency", cyc - t_d3, SC + 2);
            lat_arm = 1'b0;
          end
        end
      end
    end
  end

  task automatic show(input int d, input logic [6:0] m, input int n);
    an_n = 4'hF;
    an_n[d] = 1'b0;
    seg_n = ~m;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    an_n = 4'hF;
    seg_n = 7'h7F;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [6:0] m0, input logic [6:0] m1,
                       input logic [6:0] m2, input logic [6:0] m3);
    show(0, m0, 6);
    show(1, m1, 6);
    show(2, m2, 6);
    t_d3 = cyc;
    show(3, m3, 6);
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("reset_chars", int'({char3, char2, char1, char0}), 0);
    chk("reset_cnt", int'(word_cnt), 0);
    chk("reset_flags", int'({word_valid, char_err, scan_err}), 0);

    // First word HAPP, with the completing-digit latency measured.
    push(4'd5, 4'd1, 4'd8, 4'd8, 1'b0, 8'd1);
    lat_arm = 1'b1;
    frame(M_H, M_A, M_P, M_P);
    // Identical word twice more must stay silent.
    frame(M_H, M_A, M_P, M_P);
    frame(M_H, M_A, M_P, M_P);
    idle(3);
    chk("dup_suppressed_cnt", int'(word_cnt), 1);
    push(4'd1, 4'd8, 4'd8, 4'd11, 1'b0, 8'd2);
    frame(M_A, M_P, M_P, M_Y);
    idle(3);

    // Digit 2 held one cycle short: no commit until it is re-held.
    push(4'd9, 4'd10, 4'd7, 4'd8, 1'b0, 8'd3);
    show(0, M_S, 6);
    show(1, M_T, 6);
    show(2, M_O, SC - 1);
    show(3, M_P, 6);
    idle(4);
    chk("short_dwell_cnt", int'(word_cnt), 2);
    show(2, M_O, 6);
    idle(4);
    chk("short_dwell_commit_cnt", int'(word_cnt), 3);

    // Two enables low for 5 cycles: one scan_err, digit 0 survives.
    push(4'd2, 4'd1, 4'd6, 4'd4, 1'b0, 8'd4);
    show(0, M_B, 6);
    an_n = 4'b1100;
    seg_n = ~M_A;
    repeat (5) begin @(posedge clk); #1; end
    show(1, M_A, 6);
    chk("scan_err_pulses", scan_seen, 1);
    chk("multi_no_commit_cnt", int'(word_cnt), 3);
    show(2, M_N, 6);
    show(3, M_D, 6);
    idle(4);

    // Undecodable glyph on digit 1.
    push(4'd5, 4'd15, 4'd10, 4'd9, 1'b1, 8'd5);
    frame(M_H, M_X, M_T, M_S);
    idle(4);

    // Reset after three accepted digits discards the partial frame.
    show(0, M_H, 6);
    show(1, M_A, 6);
    show(2, M_P, 6);
    rst = 1'b1;
    an_n = 4'hF;
    seg_n = 7'h7F;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_chars", int'({char3, char2, char1, char0}), 0);
    chk("rst2_cnt", int'(word_cnt), 0);
    chk("rst2_flags", int'({word_valid, char_err, scan_err}), 0);
    show(3, M_P, 6);
    idle(4);
    chk("rst2_partial_cnt", int'(word_cnt), 0);
    push(4'd5, 4'd1, 4'd8, 4'd8, 1'b0, 8'd1);
    show(0, M_H, 6);
    show(1, M_A, 6);
    show(2, M_P, 6);
    idle(4);

    for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    chk("scoreboard_drained", sb.size(), 0);
    chk("total_word_valid", wv_seen, 6);
    chk("total_scan_err", scan_seen, 1);
    chk("final_cnt", int'(word_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
